// File: rtl/inout8_bus_ctrl.sv
// 8080-style 8-bit parallel bus sequencer.
// Runs one single-byte read or write at a time with programmable setup,
// strobe and hold lengths. Idle turnaround cycles are inserted whenever the
// transfer direction changes, so the pin driver and the peripheral never
// drive the data lines at the same time. Every output comes straight from a
// flop; the next output values are decoded from the next state.
module inout8_bus_ctrl #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned TURN_CYC   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [7:0] io_write,
    output logic       io_write_enable,
    input  logic [7:0] io_read,
    output logic       bus_cs_n,
    output logic       bus_rs,
    output logic       bus_wr_n,
    output logic       bus_rd_n
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TURN   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t     state_reg, state_next;

    // Latched request fields.
    logic       lat_write_reg, lat_write_next;
    logic       lat_rs_reg, lat_rs_next;
    logic [7:0] lat_data_reg, lat_data_next;

    // Direction of the last transfer that owned the bus: 0 = read, 1 = write.
    logic       last_dir_reg, last_dir_next;

    // Registered outputs.
    logic       req_ready_reg, req_ready_next;
    logic       rsp_valid_reg, rsp_valid_next;
    logic [7:0] rsp_data_reg, rsp_data_next;
    logic [7:0] io_write_reg, io_write_next;
    logic       oe_reg, oe_next;
    logic       cs_n_reg, cs_n_next;
    logic       bus_rs_reg, bus_rs_next;
    logic       wr_n_reg, wr_n_next;
    logic       rd_n_reg, rd_n_next;

    logic       accept;

    // Per-state "last cycle of this state" flags: 0 TURN, 1 SETUP, 2 STROBE, 3 HOLD.
    logic [3:0] cnt_zero;

    // One down-counter per timed state. It is loaded with (length - 1) on the
    // edge that enters the state and counts down while the state is held, so
    // the state exits on the edge where its counter reads zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            localparam int unsigned LEN = (gi == 0) ? TURN_CYC  :
                                          (gi == 1) ? SETUP_CYC :
                                          (gi == 2) ? STROBE_CYC : HOLD_CYC;
            localparam logic [3:0] LOAD_VAL = 4'(LEN - 1);
            localparam state_t     MY_STATE = state_t'(3'(gi + 1));

            logic [3:0] cnt_reg;

            // Load on entry, decrement while dwelling in the state.
            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_reg <= 4'd0;
                end else if (state_next == MY_STATE && state_reg != MY_STATE) begin
                    cnt_reg <= LOAD_VAL;
                end else if (state_reg == MY_STATE && cnt_reg != 4'd0) begin
                    cnt_reg <= cnt_reg - 4'd1;
                end
            end

            assign cnt_zero[gi] = (cnt_reg == 4'd0);
        end
    endgenerate

    // State, latched request and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            lat_write_reg <= 1'b0;
            lat_rs_reg    <= 1'b0;
            lat_data_reg  <= 8'h00;
            last_dir_reg  <= 1'b0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 8'h00;
            io_write_reg  <= 8'h00;
            oe_reg        <= 1'b0;
            cs_n_reg      <= 1'b1;
            bus_rs_reg    <= 1'b0;
            wr_n_reg      <= 1'b1;
            rd_n_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            lat_write_reg <= lat_write_next;
            lat_rs_reg    <= lat_rs_next;
            lat_data_reg  <= lat_data_next;
            last_dir_reg  <= last_dir_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            io_write_reg  <= io_write_next;
            oe_reg        <= oe_next;
            cs_n_reg      <= cs_n_next;
            bus_rs_reg    <= bus_rs_next;
            wr_n_reg      <= wr_n_next;
            rd_n_reg      <= rd_n_next;
        end
    end

    // Next-state logic, read capture, and output decode from the next state.
    always_comb begin
        state_next     = state_reg;
        lat_write_next = lat_write_reg;
        lat_rs_next    = lat_rs_reg;
        lat_data_next  = lat_data_reg;
        last_dir_next  = last_dir_reg;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data_reg;
        accept         = req_valid && req_ready_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    lat_write_next = req_write;
                    lat_rs_next    = req_rs;
                    lat_data_next  = req_data;
                    state_next     = (req_write != last_dir_reg) ? ST_TURN : ST_SETUP;
                end
            end
            ST_TURN: begin
                if (cnt_zero[0]) begin
                    state_next    = ST_SETUP;
                    last_dir_next = lat_write_reg;
                end
            end
            ST_SETUP: begin
                if (cnt_zero[1]) begin
                    state_next = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (cnt_zero[2]) begin
                    state_next = ST_HOLD;
                    // Sample the pins while rd_n is still low.
                    if (!lat_write_reg) begin
                        rsp_valid_next = 1'b1;
                        rsp_data_next  = io_read;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_zero[3]) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Idle/turnaround values: bus released, strobes high, driver off.
        req_ready_next = (state_next == ST_IDLE);
        cs_n_next      = 1'b1;
        wr_n_next      = 1'b1;
        rd_n_next      = 1'b1;
        oe_next        = 1'b0;
        io_write_next  = io_write_reg;
        bus_rs_next    = bus_rs_reg;

        if (state_next == ST_SETUP || state_next == ST_STROBE || state_next == ST_HOLD) begin
            cs_n_next   = 1'b0;
            bus_rs_next = lat_rs_next;
            if (lat_write_next) begin
                oe_next       = 1'b1;
                io_write_next = lat_data_next;
            end
        end

        if (state_next == ST_STROBE) begin
            if (lat_write_next) begin
                wr_n_next = 1'b0;
            end else begin
                rd_n_next = 1'b0;
            end
        end
    end

    assign req_ready       = req_ready_reg;
    assign rsp_valid       = rsp_valid_reg;
    assign rsp_data        = rsp_data_reg;
    assign io_write        = io_write_reg;
    assign io_write_enable = oe_reg;
    assign bus_cs_n        = cs_n_reg;
    assign bus_rs          = bus_rs_reg;
    assign bus_wr_n        = wr_n_reg;
    assign bus_rd_n        = rd_n_reg;

endmodule

// File: tb/tb_inout8_bus_ctrl.sv
// Directed testbench for inout8_bus_ctrl: default timing instance plus an
// instance with non-default timing. Observation vectors are
// {req_ready, bus_cs_n, bus_wr_n, bus_rd_n, io_write_enable, rsp_valid}.
module tb_inout8_bus_ctrl;

    logic       clock;
    logic       reset;

    logic       req_valid, req_ready, req_write, req_rs;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [7:0] io_write;
    logic       io_write_enable;
    logic [7:0] io_read;
    logic       bus_cs_n, bus_rs, bus_wr_n, bus_rd_n;
    logic [7:0] read_byte;

    logic       p_req_valid, p_req_ready, p_req_write, p_req_rs;
    logic [7:0] p_req_data;
    logic       p_rsp_valid;
    logic [7:0] p_rsp_data;
    logic [7:0] p_io_write;
    logic       p_io_write_enable;
    logic [7:0] p_io_read;
    logic       p_bus_cs_n, p_bus_rs, p_bus_wr_n, p_bus_rd_n;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Peripheral model: drives read_byte only while rd_n is low.
    assign io_read   = bus_rd_n ? 8'hFF : read_byte;
    assign p_io_read = 8'h00;

    inout8_bus_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_rs(req_rs), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .io_write(io_write), .io_write_enable(io_write_enable), .io_read(io_read),
        .bus_cs_n(bus_cs_n), .bus_rs(bus_rs), .bus_wr_n(bus_wr_n), .bus_rd_n(bus_rd_n)
    );

    inout8_bus_ctrl #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .TURN_CYC(1)) dut_p (
        .clock(clock), .reset(reset),
        .req_valid(p_req_valid), .req_ready(p_req_ready), .req_write(p_req_write),
        .req_rs(p_req_rs), .req_data(p_req_data),
        .rsp_valid(p_rsp_valid), .rsp_data(p_rsp_data),
        .io_write(p_io_write), .io_write_enable(p_io_write_enable), .io_read(p_io_read),
        .bus_cs_n(p_bus_cs_n), .bus_rs(p_bus_rs), .bus_wr_n(p_bus_wr_n), .bus_rd_n(p_bus_rd_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [5:0] obs();
        return {req_ready, bus_cs_n, bus_wr_n, bus_rd_n, io_write_enable, rsp_valid};
    endfunction

    function automatic logic [5:0] obs_p();
        return {p_req_ready, p_bus_cs_n, p_bus_wr_n, p_bus_rd_n, p_io_write_enable, p_rsp_valid};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total_cnt++;
        if (obs() !== 6'b111100) $display("FAIL reset_ctrl: got %b want 111100", obs());
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== 8'h00 || io_write !== 8'h00 || bus_rs !== 1'b0)
            $display("FAIL reset_data: rsp_data=%h io_write=%h rs=%b want 00 00 0", rsp_data, io_write, bus_rs);
        else pass_cnt++;
        total_cnt++;
        if (obs_p() !== 6'b111100) $display("FAIL reset_ctrl_p: got %b want 111100", obs_p());
        else pass_cnt++;
        $display("reset done");
    endtask

    task automatic test_write_turn();
        logic [5:0] exp [7] = '{6'b011100, 6'b011100, 6'b001110, 6'b000110,
                                6'b000110, 6'b001110, 6'b111100};
        req_valid = 1'b1; req_write = 1'b1; req_rs = 1'b1; req_data = 8'hA5;
        tick();
        req_valid = 1'b0;
        $display("write rs=1 data=a5 accepted");
        for (int k = 0; k < 7; k++) begin
            total_cnt++;
            if (obs() !== exp[k]) $display("FAIL write_turn c%0d: got %b want %b", k, obs(), exp[k]);
            else pass_cnt++;
            if (k == 2) begin
                total_cnt++;
                if (io_write !== 8'hA5 || bus_rs !== 1'b1)
                    $display("FAIL write_turn_data: io_write=%h rs=%b want a5 1", io_write, bus_rs);
                else pass_cnt++;
            end
            if (k < 6) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp [10] = '{6'b001110, 6'b000110, 6'b000110, 6'b001110, 6'b111100,
                                 6'b001110, 6'b000110, 6'b000110, 6'b001110, 6'b111100};
        logic prev_wr = 1'b1;
        int   falls = 0;
        req_valid = 1'b1; req_write = 1'b1; req_rs = 1'b0; req_data = 8'h11;
        tick();
        req_data = 8'h22;
        $display("write data=11 accepted, data=22 held pending");
        for (int k = 0; k < 10; k++) begin
            if (k == 5) req_valid = 1'b0;
            if (prev_wr && !bus_wr_n) falls++;
            prev_wr = bus_wr_n;
            total_cnt++;
            if (obs() !== exp[k]) $display("FAIL b2b c%0d: got %b want %b", k, obs(), exp[k]);
            else pass_cnt++;
            if (k == 0 || k == 5) begin
                total_cnt++;
                if (io_write !== ((k == 0) ? 8'h11 : 8'h22))
                    $display("FAIL b2b_data c%0d: got %h want %h", k, io_write, (k == 0) ? 8'h11 : 8'h22);
                else pass_cnt++;
            end
            if (k < 9) tick();
        end
        total_cnt++;
        if (falls !== 2) $display("FAIL b2b_wr_falls: got %0d want 2", falls);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic [5:0] exp [7] = '{6'b011100, 6'b011100, 6'b001100, 6'b001000,
                                6'b001000, 6'b001101, 6'b111100};
        req_valid = 1'b1; req_write = 1'b1; req_rs = 1'b0; req_data = 8'h55;
        tick();
        req_valid = 1'b0;
        $display("write data=55 accepted");
        total_cnt++;
        if (io_write !== 8'h55 || io_write_enable !== 1'b1)
            $display("FAIL wr55_setup: io_write=%h oe=%b want 55 1", io_write, io_write_enable);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) tick();
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL wr55_done: ready=%b want 1", req_ready);
        else pass_cnt++;
        read_byte = 8'h3C;
        req_valid = 1'b1; req_write = 1'b0; req_rs = 1'b0;
        tick();
        req_valid = 1'b0;
        $display("read rs=0 accepted");
        for (int k = 0; k < 7; k++) begin
            total_cnt++;
            if (obs() !== exp[k]) $display("FAIL wr_rd c%0d: got %b want %b", k, obs(), exp[k]);
            else pass_cnt++;
            if (k == 5) begin
                total_cnt++;
                if (rsp_data !== 8'h3C) $display("FAIL wr_rd_data: got %h want 3c", rsp_data);
                else pass_cnt++;
            end
            if (k < 6) tick();
        end
    endtask

    task automatic test_read_write();
        logic [5:0] exp [12] = '{6'b001100, 6'b001000, 6'b001000, 6'b001101, 6'b111100,
                                 6'b011100, 6'b011100, 6'b001110, 6'b000110, 6'b000110,
                                 6'b001110, 6'b111100};
        logic prev_rd = 1'b1;
        int   since_rise = 99;
        read_byte = 8'hC3;
        req_valid = 1'b1; req_write = 1'b0; req_rs = 1'b1;
        tick();
        req_valid = 1'b0;
        $display("read rs=1 accepted, then write data=9a");
        for (int k = 0; k < 12; k++) begin
            if (k == 4) begin
                req_valid = 1'b1; req_write = 1'b1; req_data = 8'h9A;
            end
            if (k == 5) req_valid = 1'b0;
            if (!prev_rd && bus_rd_n) since_rise = 0;
            else if (since_rise < 99) since_rise++;
            prev_rd = bus_rd_n;
            total_cnt++;
            if (obs() !== exp[k]) $display("FAIL rd_wr c%0d: got %b want %b", k, obs(), exp[k]);
            else pass_cnt++;
            total_cnt++;
            if (io_write_enable && (!bus_rd_n || since_rise <= 2))
                $display("FAIL rd_wr_overlap c%0d: oe=%b rd_n=%b since_rise=%0d want no drive", k, io_write_enable, bus_rd_n, since_rise);
            else pass_cnt++;
            if (k == 3) begin
                total_cnt++;
                if (rsp_data !== 8'hC3) $display("FAIL rd_wr_data: got %h want c3", rsp_data);
                else pass_cnt++;
            end
            if (k < 11) tick();
        end
    endtask

    task automatic test_reset_mid_read();
        logic [5:0] exp_a [5] = '{6'b011100, 6'b011100, 6'b001100, 6'b001000, 6'b001000};
        logic [5:0] exp_b [5] = '{6'b001100, 6'b001000, 6'b001000, 6'b001101, 6'b111100};
        read_byte = 8'h77;
        req_valid = 1'b1; req_write = 1'b0; req_rs = 1'b0;
        tick();
        req_valid = 1'b0;
        $display("read accepted, reset in second strobe cycle");
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if (obs() !== exp_a[k]) $display("FAIL mid_rd c%0d: got %b want %b", k, obs(), exp_a[k]);
            else pass_cnt++;
            if (k < 4) tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (obs() !== 6'b111100) $display("FAIL mid_rd_reset: got %b want 111100", obs());
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== 8'h00) $display("FAIL mid_rd_rsp_data: got %h want 00", rsp_data);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if (rsp_valid !== 1'b0) $display("FAIL mid_rd_no_rsp c%0d: got %b want 0", k, rsp_valid);
            else pass_cnt++;
        end
        read_byte = 8'h5A;
        req_valid = 1'b1; req_write = 1'b0; req_rs = 1'b1;
        tick();
        req_valid = 1'b0;
        $display("read rs=1 after reset accepted");
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if (obs() !== exp_b[k]) $display("FAIL post_rst_rd c%0d: got %b want %b", k, obs(), exp_b[k]);
            else pass_cnt++;
            if (k == 3) begin
                total_cnt++;
                if (rsp_data !== 8'h5A || bus_rs !== 1'b1)
                    $display("FAIL post_rst_rd_data: rsp=%h rs=%b want 5a 1", rsp_data, bus_rs);
                else pass_cnt++;
            end
            if (k < 4) tick();
        end
    endtask

    task automatic test_params();
        logic [5:0] exp [8] = '{6'b011100, 6'b001110, 6'b001110, 6'b001110,
                                6'b000110, 6'b001110, 6'b001110, 6'b111100};
        int low_cnt = 0;
        p_req_valid = 1'b1; p_req_write = 1'b1; p_req_rs = 1'b0; p_req_data = 8'hC7;
        tick();
        p_req_valid = 1'b0;
        $display("param instance write data=c7 accepted");
        for (int k = 0; k < 8; k++) begin
            if (!p_bus_wr_n) low_cnt++;
            total_cnt++;
            if (obs_p() !== exp[k]) $display("FAIL params c%0d: got %b want %b", k, obs_p(), exp[k]);
            else pass_cnt++;
            if (k == 1) begin
                total_cnt++;
                if (p_io_write !== 8'hC7) $display("FAIL params_data: got %h want c7", p_io_write);
                else pass_cnt++;
            end
            if (k < 7) tick();
        end
        total_cnt++;
        if (low_cnt !== 1) $display("FAIL params_strobe_len: got %0d want 1", low_cnt);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        p_req_valid = 1'b0; p_req_write = 1'b0; p_req_rs = 1'b0; p_req_data = 8'h00;
        read_byte = 8'h00;
        test_reset();
        test_write_turn();
        test_back_to_back();
        test_write_read();
        test_read_write();
        test_reset_mid_read();
        test_params();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/inout8_bus_ctrl.md
Name: inout8_bus_ctrl

Overview:
Transaction sequencer for an 8-bit bidirectional parallel bus of the 8080 style, used for LCD controllers and 8-bit peripherals. It drives the write data, output-enable and read-data nets of the 8-bit tri-state pin wrapper, plus chip-select, register-select and read/write strobes. It accepts one single-byte read or write at a time over a valid/ready handshake. It applies programmable setup, strobe and hold timing, and inserts bus-turnaround cycles whenever the transfer direction changes, so the two bus drivers never overlap.

Parameters:
SETUP_CYC, 1, cycles of cs_n/rs/data valid before the strobe falls (legal values 1 to 15)
STROBE_CYC, 2, cycles the strobe is held low (legal values 1 to 15)
HOLD_CYC, 1, cycles after the strobe rises before cs_n is released (legal values 1 to 15)
TURN_CYC, 2, idle cycles with the bus undriven on a direction change (legal values 1 to 15)

Ports:
clock  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write, 0 = read
req_rs  in  1  register-select value for the transaction
req_data  in  8  write byte
rsp_valid  out  1  one-cycle pulse when read data is valid
rsp_data  out  8  last byte read
io_write  out  8  to the pin wrapper: byte to drive
io_write_enable  out  1  to the pin wrapper: drive the pins
io_read  in  8  from the pin wrapper: sampled pin value
bus_cs_n  out  1  chip select, active low
bus_rs  out  1  register select
bus_wr_n  out  1  write strobe, active low
bus_rd_n  out  1  read strobe, active low

Behaviour:
- Interface: one clock, `clock`; synchronous active-high `reset`. All outputs are registered.
- States: IDLE, TURN, SETUP, STROBE, HOLD. Each state has its own down-counter loaded from its parameter.
- Registered `last_dir`: 0 = read, 1 = write. Reset value 0.
- Reset values:
  - state = IDLE
  - req_ready = 1, rsp_valid = 0, rsp_data = 0x00
  - io_write = 0x00, io_write_enable = 0
  - bus_cs_n = 1, bus_rs = 0, bus_wr_n = 1, bus_rd_n = 1
- req_ready = 1 only in IDLE.
- A request is accepted on an edge where req_valid && req_ready. On acceptance, req_write, req_rs and req_data are latched.
- Next state after acceptance: TURN if req_write != last_dir, otherwise SETUP.
- TURN: lasts TURN_CYC cycles. cs_n = 1, both strobes = 1, io_write_enable = 0. last_dir is updated on exit.
- SETUP: lasts SETUP_CYC cycles. cs_n = 0, bus_rs = latched rs. For a write: io_write = latched data and io_write_enable = 1.
- STROBE: lasts STROBE_CYC cycles. For a write, bus_wr_n = 0; for a read, bus_rd_n = 0. Write data and enable are held.
- HOLD: lasts HOLD_CYC cycles. Strobes = 1, cs_n = 0, write data and enable are held. Then go to IDLE, where cs_n = 1 and io_write_enable = 0.
- Read capture: io_read is registered into rsp_data on the edge that ends the last STROBE cycle. rsp_valid = 1 for exactly the first HOLD cycle. rsp_data holds its value until the next read capture.
- Latency:
  - Same direction: busy for SETUP+STROBE+HOLD cycles after acceptance, then req_ready returns.
  - Direction change: TURN_CYC is added.
  - There is always at least one IDLE cycle between transactions.
- io_write_enable is never 1 while bus_rd_n = 0, and never 1 in TURN.
- A write's io_write_enable never rises until TURN_CYC cycles have passed since the last read's rd_n rise.
- req_valid while busy is ignored. It must be held by the requester until it is accepted, and is accepted exactly once.
- Reset mid-transaction: on the next edge go to IDLE with all reset values, immediately releasing the bus and strobes. An in-flight read gives no rsp_valid.

Test Plan:
1. Defaults, after reset, write rs=1 data 0xA5 → 2 TURN cycles with oe=0 and cs_n=1; 1 SETUP cycle with oe=1, io_write=0xA5, rs=1; 2 cycles wr_n=0; 1 HOLD cycle; req_ready returns 6 cycles after acceptance.
2. Two back-to-back writes, 0x11 then 0x22, with req_valid held high → no TURN on the second; each transaction busy 4 cycles; exactly 1 IDLE cycle between; wr_n falls exactly twice.
3. Write 0x55 then read, with the model driving 0x3C on io_read while rd_n=0 → 2 TURN cycles before the read; oe=0 during the entire read; rd_n low for 2 cycles; rsp_valid single pulse with rsp_data=0x3C in the HOLD cycle.
4. Read then write → TURN inserted; the checker asserts (oe && !rd_n) is never true, and oe is never 1 within 2 cycles of rd_n rising.
5. Reset asserted during the second STROBE cycle of a read → the next cycle shows cs_n=1, rd_n=1, oe=0, req_ready=1, and rsp_valid is never pulsed; a following read from reset gets no TURN, since last_dir=read.
6. Parameters SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2, TURN_CYC=1 on a write → 1+3+1+2 = 7 busy cycles, with the strobe low for exactly 1 cycle.
